// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - fetch program counter with prioritised redirects and stall-pending slot
// Optional feature macro: MISALIGN_CHECK_EN (reject misaligned redirect targets instead of aligning them)
module pc_next_unit #(
  parameter int                XLEN         = 32,
  parameter int                NUM_SRC      = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                STEP         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic [NUM_SRC-1:0]      redirect_valid_i,
  input  logic [NUM_SRC*XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0]         pc_o,
  output logic [XLEN-1:0]         pc_plus4_o,
  output logic                    pc_valid_o,
  output logic [NUM_SRC-1:0]      redirect_taken_o,
  output logic                    misalign_o,
  output logic [XLEN-1:0]         misalign_addr_o
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [XLEN-1:0]    pc_q;
  logic               pc_valid_q;
  logic [NUM_SRC-1:0] taken_q;

  logic               pending_valid;
  logic [SRC_W-1:0]   pending_src;
  logic [XLEN-1:0]    pending_target;

  logic               live_any;
  logic [SRC_W-1:0]   live_src;
  logic [XLEN-1:0]    live_target;

  logic               cand_any;
  logic [SRC_W-1:0]   cand_src;
  logic [XLEN-1:0]    cand_target;
  logic [XLEN-1:0]    cand_aligned;
  logic [NUM_SRC-1:0] cand_onehot;
  logic [XLEN-1:0]    pc_step;

`ifdef MISALIGN_CHECK_EN
  logic               cand_misaligned;
  logic               misalign_q;
  logic [XLEN-1:0]    misalign_addr_q;
`endif

  // Fixed-priority pick of the live redirect: lowest asserted index wins
  always_comb begin
    live_any = 1'b0;
    live_src = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (redirect_valid_i[k]) begin
        live_any = 1'b1;
        live_src = SRC_W'(k);
      end
    end
    live_target = redirect_target_i[int'(live_src) * XLEN +: XLEN];
  end

  // Candidate: a live winner of equal or higher priority beats the pending entry
  always_comb begin
    cand_any    = 1'b0;
    cand_src    = '0;
    cand_target = '0;
    if (pending_valid && live_any && (live_src <= pending_src)) begin
      cand_any    = 1'b1;
      cand_src    = live_src;
      cand_target = live_target;
    end else if (pending_valid) begin
      cand_any    = 1'b1;
      cand_src    = pending_src;
      cand_target = pending_target;
    end else if (live_any) begin
      cand_any    = 1'b1;
      cand_src    = live_src;
      cand_target = live_target;
    end
    cand_aligned = cand_target & ~XLEN'(3);
    cand_onehot  = NUM_SRC'(1) << cand_src;
    pc_step      = pc_q + XLEN'(STEP);
`ifdef MISALIGN_CHECK_EN
    cand_misaligned = (cand_target[1:0] != 2'b00);
`endif
  end

  // PC, pending slot and pulse outputs; first edge after reset is a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_VECTOR;
      pc_valid_q     <= 1'b0;
      taken_q        <= '0;
      pending_valid  <= 1'b0;
      pending_src    <= '0;
      pending_target <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
      taken_q <= '0;
`ifdef MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
      if (!pc_valid_q) begin
        // Bubble: redirects on this edge are dropped, not pended
        pc_valid_q <= 1'b1;
      end else if (stall_i) begin
        // Misalignment is judged at apply time, so pend the raw target
        if (cand_any) begin
          pending_valid  <= 1'b1;
          pending_src    <= cand_src;
          pending_target <= cand_target;
        end
      end else begin
        pending_valid <= 1'b0;
        if (cand_any) begin
`ifdef MISALIGN_CHECK_EN
          if (cand_misaligned) begin
            pc_q            <= pc_step;
            misalign_q      <= 1'b1;
            misalign_addr_q <= cand_target;
          end else begin
            pc_q    <= cand_aligned;
            taken_q <= cand_onehot;
          end
`else
          pc_q    <= cand_aligned;
          taken_q <= cand_onehot;
`endif
        end else begin
          pc_q <= pc_step;
        end
      end
    end
  end

  assign pc_o             = pc_q;
  assign pc_plus4_o       = pc_q + XLEN'(STEP);
  assign pc_valid_o       = pc_valid_q;
  assign redirect_taken_o = taken_q;

`ifdef MISALIGN_CHECK_EN
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`else
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - table-driven directed bench for pc_next_unit
module tb_pc_next_unit;

  logic         clk;
  logic         rst_n;
  logic         stall_i;
  logic [3:0]   redirect_valid_i;
  logic [127:0] redirect_target_i;
  logic [31:0]  pc_o;
  logic [31:0]  pc_plus4_o;
  logic         pc_valid_o;
  logic [3:0]   redirect_taken_o;
  logic         misalign_o;
  logic [31:0]  misalign_addr_o;

  pc_next_unit #(
    .XLEN(32), .NUM_SRC(4), .RESET_VECTOR(32'h0000_0100), .STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .pc_valid_o(pc_valid_o),
    .redirect_taken_o(redirect_taken_o), .misalign_o(misalign_o),
    .misalign_addr_o(misalign_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             stall;
    logic [3:0]       valid;
    logic [3:0][31:0] tgt;
    logic [31:0]      exp_pc;
    logic [3:0]       exp_taken;
    logic             exp_mis;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec;
  int          n_err;
  logic [31:0] base;
  logic [31:0] last_pc;

  function automatic vec_t mk(logic s, logic [3:0] v, logic [31:0] t3, logic [31:0] t2,
                              logic [31:0] t1, logic [31:0] t0, logic [31:0] ep,
                              logic [3:0] et, logic em);
    vec_t r;
    r.stall = s; r.valid = v;
    r.tgt[3] = t3; r.tgt[2] = t2; r.tgt[1] = t1; r.tgt[0] = t0;
    r.exp_pc = ep; r.exp_taken = et; r.exp_mis = em;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic [3:0] v, logic [3:0][31:0] t);
    stall_i = s;
    redirect_valid_i = v;
    redirect_target_i = t;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, '0);

`ifdef MISALIGN_CHECK_EN
    base = 32'h0000_0004;
`else
    base = 32'h0000_0200;
`endif

    // bubble edge: redirect on ch0 must be dropped
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 32'h800, 32'h100, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h104, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h108, 4'b0000, 0));
    // ch3 and ch1 together: ch1 wins
    vecs.push_back(mk(0, 4'b1010, 32'h200, 0, 32'h300, 0, 32'h300, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h304, 4'b0000, 0));
    // stall: ch3 then ch2 pended, ch2 replaces ch3
    vecs.push_back(mk(1, 4'b1000, 32'h400, 0, 0, 0, 32'h304, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 32'h500, 0, 0, 32'h304, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 32'h304, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h500, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h504, 4'b0000, 0));
    // pending ch2 versus live ch0 at release
    vecs.push_back(mk(1, 4'b0100, 0, 32'h600, 0, 0, 32'h504, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 32'h40, 32'h40, 4'b0001, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h44, 4'b0000, 0));
    // lower-priority ch3 must not displace pending ch1
    vecs.push_back(mk(1, 4'b0010, 0, 0, 32'h700, 0, 32'h44, 4'b0000, 0));
    vecs.push_back(mk(1, 4'b1000, 32'h900, 0, 0, 0, 32'h44, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h700, 4'b0010, 0));
    // wrap at top of address space
    vecs.push_back(mk(0, 4'b0100, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'h0000_0000, 4'b0000, 0));
    // misaligned target on ch0
`ifdef MISALIGN_CHECK_EN
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 32'h202, base, 4'b0000, 1));
`else
    vecs.push_back(mk(0, 4'b0001, 0, 0, 0, 32'h202, base, 4'b0001, 0));
`endif
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, base + 32'd4, 4'b0000, 0));
    // equal priority: newer live ch1 beats pending ch1
    vecs.push_back(mk(1, 4'b0010, 0, 0, 32'hA00, 0, base + 32'd4, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 32'hB00, 0, 32'hB00, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 32'hB04, 4'b0000, 0));

    // reset state
    @(negedge clk);
    n_vec++;
    chk("reset_pc", pc_o, 32'h100);
    chk("reset_valid", {31'd0, pc_valid_o}, 32'd0);
    chk("reset_taken", {28'd0, redirect_taken_o}, 32'd0);
    chk("reset_mis", {31'd0, misalign_o}, 32'd0);
    chk("reset_mis_addr", misalign_addr_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].tgt);
      @(posedge clk);
      #1;
      n_vec++;
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      chk($sformatf("v%0d_plus4", i), pc_plus4_o, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_valid", i), {31'd0, pc_valid_o}, 32'd1);
      chk($sformatf("v%0d_taken", i), {28'd0, redirect_taken_o}, {28'd0, vecs[i].exp_taken});
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_o}, {31'd0, vecs[i].exp_mis});
`ifdef MISALIGN_CHECK_EN
      if (i >= 18) chk($sformatf("v%0d_mis_addr", i), misalign_addr_o, 32'h202);
`else
      chk($sformatf("v%0d_mis_addr", i), misalign_addr_o, 32'd0);
`endif
      @(negedge clk);
    end
    last_pc = 32'hB04;

`ifdef MISALIGN_CHECK_EN
    // pended misaligned redirect is rejected at stall release
    drive(1'b1, 4'b0010, {32'd0, 32'd0, 32'h302, 32'd0});
    @(posedge clk); #1;
    n_vec++;
    chk("pend_mis_hold_pc", pc_o, last_pc);
    @(negedge clk);
    drive(1'b0, 4'b0000, '0);
    @(posedge clk); #1;
    n_vec++;
    chk("pend_mis_pc", pc_o, last_pc + 32'd4);
    chk("pend_mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("pend_mis_addr", misalign_addr_o, 32'h302);
    chk("pend_mis_taken", {28'd0, redirect_taken_o}, 32'd0);
    @(negedge clk);
    last_pc = last_pc + 32'd4;
`endif

    // reset asserted mid-stall with a pending redirect
    drive(1'b1, 4'b0001, {32'd0, 32'd0, 32'd0, 32'h1000});
    @(posedge clk); #1;
    n_vec++;
    chk("stall_pend_pc", pc_o, last_pc);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    chk("midreset_pc", pc_o, 32'h100);
    chk("midreset_valid", {31'd0, pc_valid_o}, 32'd0);
    @(negedge clk);
    drive(1'b0, 4'b0000, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    chk("post_rst_bubble_pc", pc_o, 32'h100);
    chk("post_rst_bubble_taken", {28'd0, redirect_taken_o}, 32'd0);
    chk("post_rst_valid", {31'd0, pc_valid_o}, 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    n_vec++;
    chk("post_rst_pc", pc_o, 32'h104);
    chk("post_rst_taken", {28'd0, redirect_taken_o}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    n_vec++;
    chk("post_rst_pc2", pc_o, 32'h108);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Next-generation program-counter stage for the core's fetch front end.
- Owns the PC register and selects the next PC from the sequential increment and NUM_SRC prioritised redirect channels (trap, mret, jump, branch, ...).
- Holds the PC under fetch stall and latches redirects that arrive during a stall, so no redirect is lost.
- Feeds the instruction-memory address and the IF/ID PC+4 path.

Parameters:
XLEN, 32, PC/target width in bits
NUM_SRC, 4, number of redirect channels; index 0 = highest priority
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
STEP, 4, sequential increment in bytes

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  1 = hold PC this cycle (fetch/hazard stall)
redirect_valid_i  input  NUM_SRC  per-channel redirect request, level, sampled each clk
redirect_target_i  input  NUM_SRC*XLEN  packed targets; channel k occupies bits [k*XLEN +: XLEN]
pc_o  output  XLEN  current PC
pc_plus4_o  output  XLEN  pc_o + STEP, combinational from pc_o, modulo 2^XLEN
pc_valid_o  output  1  pc_o is a valid fetch address
redirect_taken_o  output  NUM_SRC  one-hot, one-cycle pulse when channel k's target is loaded into the PC
misalign_o  output  1  one-cycle pulse: rejected misaligned redirect (feature only)
misalign_addr_o  output  XLEN  offending target, held until next misalign (feature only)

Behaviour:
- Reset (rst_n low, async):
  - pc_o = RESET_VECTOR; pc_valid_o = 0.
  - pending_valid = 0; redirect_taken_o = 0; misalign_o = 0; misalign_addr_o = 0.
- First clk edge after rst_n rises: pc_valid_o -> 1 and pc_o stays RESET_VECTOR. This is a one-cycle bubble; stall_i and redirects are ignored on that edge.
- Arbitration: the winner is the lowest-index asserted redirect_valid_i bit. Fixed priority, no fairness.
- Internal pending slot: pending_valid, pending_src (clog2(NUM_SRC) bits), pending_target.
- Candidate redirect each cycle:
  - If pending_valid and a live winner has index <= pending_src, the live winner is the candidate (newer or higher priority wins).
  - Else the pending entry is the candidate, if pending_valid.
  - Else the live winner is the candidate, if any.
- stall_i = 0, on the clk edge:
  - If a candidate exists: pc <= candidate target; redirect_taken_o = onehot(candidate src) next cycle; pending_valid <= 0.
  - Otherwise: pc <= pc + STEP, wrapping modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
- stall_i = 1:
  - pc is held and redirect_taken_o = 0.
  - If a candidate exists, it is written into the pending slot.
  - A lower-priority redirect does not displace a higher-priority pending entry.
- Latency: redirect presented in cycle N with stall_i = 0 gives pc_o = target in cycle N+1.
- Redirect during reset bubble: dropped, not pended.
- Reset mid-stall: pending entry discarded.
- Without the feature, targets are force-aligned by clearing bits [1:0] before loading.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - A candidate whose target[1:0] != 0 is not loaded into the PC.
  - pc <= pc + STEP (or held if stalled).
  - misalign_o pulses for one cycle; misalign_addr_o = raw target.
  - redirect_taken_o stays 0; the pending slot is cleared.
  - A misaligned redirect is evaluated when it is applied, so a pended one is rejected at stall release.
  - The trap unit is expected to redirect on channel 0 afterwards.
- Undefined:
  - Targets are silently aligned (bits [1:0] cleared).
  - misalign_o tied 0; misalign_addr_o tied 0.

Test Plan:
- Reset with RESET_VECTOR=0x100, release rst_n, no redirects -> pc_o 0x100, 0x100 (pc_valid_o=1), 0x104, 0x108.
- Channels 3 (0x200) and 1 (0x300) both valid in one cycle, no stall -> next pc_o=0x300, redirect_taken_o=4'b0010; then 0x304.
- stall_i=1 for 3 cycles; channel 3 -> 0x400 in stall cycle 1, channel 2 -> 0x500 in stall cycle 2; release -> pc_o=0x500, redirect_taken_o=4'b0100; 0x400 never fetched.
- Pending channel 2 (0x600) when stall drops, live channel 0 (0x40) in the same cycle -> pc_o=0x40, taken=4'b0001.
- pc=0xFFFF_FFFC, no redirect -> pc_o=0x0000_0000; pc_plus4_o=0x4.
- Redirect to 0x202: with MISALIGN_CHECK_EN -> misalign_o pulse, misalign_addr_o=0x202, pc advances by 4. Without it -> pc_o=0x200. Assert rst_n low mid-stall with a pending redirect -> pc_o=RESET_VECTOR, no taken pulse after release.
